// File: rtl/it_pkg.sv
// Shared ITSTATE definitions: field positions, condition codes and the
// IDLE/ACTIVE phase used for debug observation of the implicit state machine.
package it_pkg;

    localparam int FC_HI   = 7;
    localparam int FC_LO   = 4;
    localparam int MASK_HI = 3;
    localparam int MASK_LO = 0;

    // Condition codes, shared with the pre-decoder's condition evaluator.
    localparam logic [3:0] COND_EQ = 4'h0;
    localparam logic [3:0] COND_NE = 4'h1;
    localparam logic [3:0] COND_CS = 4'h2;
    localparam logic [3:0] COND_CC = 4'h3;
    localparam logic [3:0] COND_MI = 4'h4;
    localparam logic [3:0] COND_PL = 4'h5;
    localparam logic [3:0] COND_VS = 4'h6;
    localparam logic [3:0] COND_VC = 4'h7;
    localparam logic [3:0] COND_HI = 4'h8;
    localparam logic [3:0] COND_LS = 4'h9;
    localparam logic [3:0] COND_GE = 4'hA;
    localparam logic [3:0] COND_LT = 4'hB;
    localparam logic [3:0] COND_GT = 4'hC;
    localparam logic [3:0] COND_LE = 4'hD;
    localparam logic [3:0] COND_AL = 4'hE;

    typedef enum logic {
        IT_IDLE   = 1'b0,
        IT_ACTIVE = 1'b1
    } it_phase_e;

    // A non-zero mask is what makes an ITSTATE value describe a live block.
    function automatic logic mask_active(input logic [7:0] s);
        return s[MASK_HI:MASK_LO] != 4'b0000;
    endfunction

endpackage

// File: rtl/it_state_ctrl_if.sv
// Pre-decoder <-> ITSTATE controller signal bundle. Restore port pair is
// present only when IT_RESTORE_EN is defined.
interface it_state_ctrl_if;
    import it_pkg::*;

    // Handshake: an instruction is issued (and ITSTATE advances) on a clock
    // edge where inst_valid=1 and stall=0; flush overrides everything.
    logic       inst_valid;
    logic       stall;
    logic       flush;
    logic       it_flag;
    logic [7:0] it_status;
    logic [3:0] it_cond;
    logic       in_it_blk;
    logic       it_last;
    logic [7:0] itstate;
    logic       it_err;
    it_phase_e  dbg_phase;
`ifdef IT_RESTORE_EN
    logic       itstate_wr;
    logic [7:0] itstate_wdata;
`endif

    modport master (
        output inst_valid, stall, flush, it_flag, it_status,
`ifdef IT_RESTORE_EN
        output itstate_wr, itstate_wdata,
`endif
        input  it_cond, in_it_blk, it_last, itstate, it_err, dbg_phase
    );

    modport slave (
        input  inst_valid, stall, flush, it_flag, it_status,
`ifdef IT_RESTORE_EN
        input  itstate_wr, itstate_wdata,
`endif
        output it_cond, in_it_blk, it_last, itstate, it_err, dbg_phase
    );

endinterface

// File: rtl/it_advance.sv
// Combinational ITAdvance for an 8-bit ITSTATE: clear on the last instruction,
// otherwise shift the low five bits left keeping the base condition.
module it_advance (
    input  logic [7:0] itstate_i,
    output logic [7:0] itstate_o
);

    always_comb begin
        itstate_o = '0;
        if (itstate_i[2:0] != 3'b000) begin
            itstate_o = {itstate_i[7:5], itstate_i[3:0], 1'b0};
        end
    end

endmodule

// File: rtl/it_state_ctrl.sv
// Thumb-2 ITSTATE holder/advancer. Define IT_RESTORE_EN to add the
// exception-return restore path (itstate_wr / itstate_wdata).
module it_state_ctrl
    import it_pkg::*;
#(
    parameter logic [7:0] RST_ITSTATE = 8'h00
) (
    input  logic           clk,
    input  logic           rst_n,
    it_state_ctrl_if.slave bus
);

    logic [7:0] itstate_q, itstate_d;
    logic       it_err_q, it_err_d;
    logic [7:0] itstate_adv;
    logic       in_blk;
    logic       adv;

    assign in_blk = mask_active(itstate_q);
    assign adv    = bus.inst_valid & ~bus.stall;

    it_advance u_advance (
        .itstate_i (itstate_q),
        .itstate_o (itstate_adv)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            itstate_q <= RST_ITSTATE;
            it_err_q  <= 1'b0;
        end else begin
            itstate_q <= itstate_d;
            it_err_q  <= it_err_d;
        end
    end

    // An IT seen while already in a block was nullified upstream, so it
    // falls through to the ordinary in-block advance.
    always_comb begin
        itstate_d = itstate_q;
        it_err_d  = 1'b0;
        if (bus.flush) begin
            itstate_d = '0;
        end
`ifdef IT_RESTORE_EN
        else if (bus.itstate_wr) begin
            itstate_d = mask_active(bus.itstate_wdata) ? bus.itstate_wdata : 8'h00;
        end
`endif
        else if (adv && bus.it_flag && !in_blk) begin
            if (mask_active(bus.it_status)) begin
                itstate_d = bus.it_status;
            end else begin
                it_err_d = 1'b1;
            end
        end else if (adv && in_blk) begin
            itstate_d = itstate_adv;
        end
    end

    assign bus.itstate   = itstate_q;
    assign bus.in_it_blk = in_blk;
    assign bus.it_cond   = in_blk ? itstate_q[FC_HI:FC_LO] : COND_AL;
    assign bus.it_last   = in_blk & (itstate_q[2:0] == 3'b000);
    assign bus.it_err    = it_err_q;
    assign bus.dbg_phase = in_blk ? IT_ACTIVE : IT_IDLE;

endmodule

// File: tb/tb_it_state_ctrl.sv
// Directed bench for it_state_ctrl; restore scenarios compile in with IT_RESTORE_EN.
module tb_it_state_ctrl;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  logic [14:0] obs;

  it_state_ctrl_if bus ();

  it_state_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {itstate, it_cond, in_it_blk, it_last, it_err}
  assign obs = {bus.itstate, bus.it_cond, bus.in_it_blk, bus.it_last, bus.it_err};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic st, input logic fl,
                       input logic itf, input logic [7:0] status);
    bus.inst_valid = v;
    bus.stall      = st;
    bus.flush      = fl;
    bus.it_flag    = itf;
    bus.it_status  = status;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
`ifdef IT_RESTORE_EN
    bus.itstate_wr    = 1'b0;
    bus.itstate_wdata = 8'h00;
`endif
    tick();
    tick();
    checks++;
    if (obs !== {8'h00, 4'hE, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset: got %h want %h", obs, {8'h00, 4'hE, 1'b0, 1'b0, 1'b0});
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_it_eq();
    drive(1'b1, 1'b0, 1'b0, 1'b1, 8'h08);
    tick();
    checks++;
    if (obs !== {8'h08, 4'h0, 1'b1, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL it_eq_load: got %h want %h", obs, {8'h08, 4'h0, 1'b1, 1'b1, 1'b0});
    end
    drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    tick();
    checks++;
    if (obs !== {8'h00, 4'hE, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL it_eq_done: got %h want %h", obs, {8'h00, 4'hE, 1'b0, 1'b0, 1'b0});
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    tick();
  endtask

  task automatic test_itte();
    logic [14:0] exp_seq [4];
    exp_seq[0] = {8'h06, 4'h0, 1'b1, 1'b0, 1'b0};
    exp_seq[1] = {8'h0C, 4'h0, 1'b1, 1'b0, 1'b0};
    exp_seq[2] = {8'h18, 4'h1, 1'b1, 1'b1, 1'b0};
    exp_seq[3] = {8'h00, 4'hE, 1'b0, 1'b0, 1'b0};
    drive(1'b1, 1'b0, 1'b0, 1'b1, 8'h06);
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (obs !== exp_seq[i]) begin
        errors++;
        $display("FAIL itte_step%0d: got %h want %h", i, obs, exp_seq[i]);
      end
      drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    tick();
  endtask

  task automatic test_four();
    logic [14:0] exp_seq [5];
    exp_seq[0] = {8'h41, 4'h4, 1'b1, 1'b0, 1'b0};
    exp_seq[1] = {8'h42, 4'h4, 1'b1, 1'b0, 1'b0};
    exp_seq[2] = {8'h44, 4'h4, 1'b1, 1'b0, 1'b0};
    exp_seq[3] = {8'h48, 4'h4, 1'b1, 1'b1, 1'b0};
    exp_seq[4] = {8'h00, 4'hE, 1'b0, 1'b0, 1'b0};
    drive(1'b1, 1'b0, 1'b0, 1'b1, 8'h41);
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (obs !== exp_seq[i]) begin
        errors++;
        $display("FAIL four_step%0d: got %h want %h", i, obs, exp_seq[i]);
      end
      drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    tick();
  endtask

  task automatic test_stall();
    drive(1'b1, 1'b0, 1'b0, 1'b1, 8'h06);
    tick();
    drive(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (obs !== {8'h06, 4'h0, 1'b1, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL stall_hold%0d: got %h want %h", i, obs, {8'h06, 4'h0, 1'b1, 1'b0, 1'b0});
      end
    end
    drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    tick();
    checks++;
    if (obs !== {8'h0C, 4'h0, 1'b1, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL stall_release: got %h want %h", obs, {8'h0C, 4'h0, 1'b1, 1'b0, 1'b0});
    end
    drive(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic test_flush();
    drive(1'b1, 1'b0, 1'b0, 1'b1, 8'h06);
    tick();
    drive(1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
    tick();
    checks++;
    if (obs !== {8'h00, 4'hE, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL flush_adv: got %h want %h", obs, {8'h00, 4'hE, 1'b0, 1'b0, 1'b0});
    end
    drive(1'b1, 1'b0, 1'b1, 1'b1, 8'h08);
    tick();
    checks++;
    if (obs !== {8'h00, 4'hE, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL flush_vs_it: got %h want %h", obs, {8'h00, 4'hE, 1'b0, 1'b0, 1'b0});
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    tick();
  endtask

  task automatic test_err();
    drive(1'b1, 1'b0, 1'b0, 1'b1, 8'h10);
    tick();
    checks++;
    if (obs !== {8'h00, 4'hE, 1'b0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL err_pulse: got %h want %h", obs, {8'h00, 4'hE, 1'b0, 1'b0, 1'b1});
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    tick();
    checks++;
    if (obs !== {8'h00, 4'hE, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL err_clear: got %h want %h", obs, {8'h00, 4'hE, 1'b0, 1'b0, 1'b0});
    end
  endtask

  task automatic test_it_in_block();
    drive(1'b1, 1'b0, 1'b0, 1'b1, 8'h06);
    tick();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    tick();
    drive(1'b1, 1'b0, 1'b0, 1'b1, 8'h08);
    tick();
    checks++;
    if (obs !== {8'h18, 4'h1, 1'b1, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL it_in_block: got %h want %h", obs, {8'h18, 4'h1, 1'b1, 1'b1, 1'b0});
    end
    drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    tick();
    checks++;
    if (obs !== {8'h00, 4'hE, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL it_in_block_end: got %h want %h", obs, {8'h00, 4'hE, 1'b0, 1'b0, 1'b0});
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    tick();
  endtask

  task automatic test_reset_mid_block();
    drive(1'b1, 1'b0, 1'b0, 1'b1, 8'h06);
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (obs !== {8'h00, 4'hE, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_mid_block: got %h want %h", obs, {8'h00, 4'hE, 1'b0, 1'b0, 1'b0});
    end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

`ifdef IT_RESTORE_EN
  task automatic test_restore();
    bus.itstate_wr    = 1'b1;
    bus.itstate_wdata = 8'hA4;
    tick();
    checks++;
    if (obs !== {8'hA4, 4'hA, 1'b1, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL restore_a4: got %h want %h", obs, {8'hA4, 4'hA, 1'b1, 1'b0, 1'b0});
    end
    bus.itstate_wdata = 8'hF0;
    tick();
    checks++;
    if (obs !== {8'h00, 4'hE, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL restore_f0: got %h want %h", obs, {8'h00, 4'hE, 1'b0, 1'b0, 1'b0});
    end
    bus.itstate_wdata = 8'hA4;
    drive(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
    tick();
    checks++;
    if (obs !== {8'h00, 4'hE, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL restore_vs_flush: got %h want %h", obs, {8'h00, 4'hE, 1'b0, 1'b0, 1'b0});
    end
    bus.itstate_wr = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    tick();
  endtask
`endif

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_it_eq();
    test_itte();
    test_four();
    test_stall();
    test_flush();
    test_err();
    test_it_in_block();
    test_reset_mid_block();
`ifdef IT_RESTORE_EN
    test_restore();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/it_state_ctrl.md
Name: it_state_ctrl

Overview:
- Holds and advances the Thumb-2 ITSTATE (EPSR IT bits) for the core.
- The pre-decoder reports an IT instruction through it_flag and it_status. This block captures those bits, then returns the current condition (it_cond) and block membership (in_it_blk) to the pre-decoder for each following instruction.
- It advances the state once per issued instruction, following ARM ITAdvance semantics.
- It clears the state on pipeline flush.

Parameters:
- RST_ITSTATE, 8'h00, ITSTATE value loaded on reset.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- inst_valid  in  1  pre-decoder output instruction issues this cycle
- stall  in  1  pipeline stall; freezes ITSTATE
- flush  in  1  branch taken or exception entry; clears ITSTATE
- it_flag  in  1  current issued instruction is IT (from pre-decoder)
- it_status  in  8  IT bits of the IT instruction: [7:4] firstcond, [3:0] mask
- it_cond  out  4  condition of the next instruction, ITSTATE[7:4]
- in_it_blk  out  1  next instruction lies inside an IT block
- it_last  out  1  next instruction is the last one of the block
- itstate  out  8  raw ITSTATE, for exception stacking
- it_err  out  1  one-cycle pulse: IT with mask 0000 was ignored

Behaviour:
- Reset (async, rst_n low): itstate=RST_ITSTATE; it_err=0. All other outputs are combinational from itstate.
- Combinational outputs:
  - in_it_blk = (itstate[3:0] != 0)
  - it_cond = itstate[7:4] when in_it_blk, else 4'b1110 (AL)
  - it_last = in_it_blk & (itstate[2:0]==3'b000)
- Advance event: adv = inst_valid & ~stall. ITSTATE updates one clock after adv. The new it_cond applies to the next issued instruction, with no bubble.
- Priority on each rising edge:
  1. flush: itstate <= 0. This wins over everything, including a same-cycle IT load.
  2. adv & it_flag & ~in_it_blk:
     - it_status[3:0] != 0: itstate <= it_status.
     - it_status[3:0] == 0: itstate unchanged, it_err <= 1.
  3. adv & it_flag & in_it_blk: the IT was already nullified upstream as unpredictable. Treat it as an ordinary in-block instruction (apply rule 4).
  4. adv & in_it_blk:
     - itstate[2:0]==000: itstate <= 0.
     - otherwise: itstate[4:0] <= itstate[4:0]<<1, and itstate[7:5] is held.
  5. Otherwise hold.
- it_err is high for exactly one cycle per ignored IT.
- States (implicit in itstate):
  - IDLE (mask==0): only an IT load moves it to ACTIVE.
  - ACTIVE: each adv shifts the mask. Returns to IDLE after the 1–4 instructions encoded by the position of the lowest set mask bit.
- stall=1 with inst_valid=1: no change. The same instruction keeps seeing the same it_cond.
- A failed-condition instruction inside the block still advances; pre_dec zeroes it, but it is still issued.
- Reset mid-block: the block is abandoned and the state returns to RST_ITSTATE.

Optional Feature:
- IT_RESTORE_EN defined:
  - Adds ports itstate_wr (in 1) and itstate_wdata (in 8) for exception return/unstacking.
  - itstate_wr loads itstate <= itstate_wdata with priority below flush and above every other rule.
  - If itstate_wdata[3:0]==0, the whole state is forced to 0.
- IT_RESTORE_EN not defined: the ports are absent and the rules are exactly as above.

Decomposition:
- Shared package it_pkg:
  - ITSTATE field localparams (FC_HI=7, FC_LO=4, MASK_HI=3, MASK_LO=0)
  - COND_AL=4'b1110
  - condition code constants (EQ..AL) shared with pre_dec's condition evaluator
- One natural sub-module, it_advance: purely combinational next-state (shift/clear) for 8-bit ITSTATE. Reusable by an exception unit computing the stacked EPSR.

Test Plan:
- IT EQ (it_status=8'h08) with adv:
  - itstate=08, it_cond=0000, in_it_blk=1, it_last=1.
  - Next adv: itstate=00, it_cond=1110, in_it_blk=0.
- ITTE EQ (it_status=8'h06), three adv:
  - it_cond sequence 0000, 0000, 0001; itstate 06→0C→18→00.
  - it_last=1 only at 18.
- Load 8'h06, then stall=1 with inst_valid=1 for 3 cycles: itstate stays 06. Releasing the stall advances to 0C.
- Load 8'h06, then flush on the same edge as the next adv: itstate=00. Also assert flush together with an IT (it_status=8'h08): itstate stays 00.
- IT with it_status=8'h10 (mask 0000) from IDLE: itstate stays 00 and it_err pulses for 1 cycle. An IT (8'h08) issued while in block at 8'h0C: state advances to 18 and is not reloaded.
- IT_RESTORE_EN:
  - itstate_wr with wdata=8'hA4: itstate=A4, it_cond=1010.
  - wdata=8'hF0: itstate=00.
  - rst_n low mid-block: itstate=00 asynchronously.
